// File: rtl/ram_uart_dumper.sv
// Walks the data RAM from address 0 upward and sends each 16-bit word as two
// 8N1 UART frames (high byte first) on a single TX line.
module ram_uart_dumper #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 6,
    parameter int NUM_WORDS    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]      BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, READ, LATCH, START, DATA, STOP, NEXT, DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [2:0]            bit_idx;
    logic [ADDR_WIDTH-1:0] index;
    logic [15:0]           word;
    logic [6:0]            shift;
    logic                  byte_sel;
    logic [7:0]            cur_byte;

    assign cur_byte = byte_sel ? word[7:0] : word[15:8];

    // tx is registered together with the state, so each line level appears on
    // the same edge that enters the state that owns it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            index     <= '0;
            word      <= '0;
            shift     <= '0;
            byte_sel  <= 1'b0;
            ram_addr  <= '0;
            ram_rd_en <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ram_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        index     <= '0;
                        ram_addr  <= '0;
                        ram_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: state <= LATCH;
                LATCH: begin
                    word     <= ram_data;
                    byte_sel <= 1'b0;
                    bit_cnt  <= '0;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (bit_cnt == BIT_END) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                        shift   <= cur_byte[7:1];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_END) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[6:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_END) begin
                        bit_cnt <= '0;
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= NEXT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    // Equality compare so a full 2^ADDR_WIDTH dump never wraps.
                    if (index == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        index     <= index + 1'b1;
                        ram_addr  <= index + 1'b1;
                        ram_rd_en <= 1'b1;
                        state     <= READ;
                    end
                end
                DONE: begin
                    tx <= 1'b1;
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_uart_dumper.sv
// Bench for ram_uart_dumper: three instances (single word, 64-word sweep,
// 2-bit address boundary) decoded by a bench UART against a byte scoreboard.
module tb_ram_uart_dumper;

    localparam int CPB = 4;
    localparam int TMO = 3000;

    logic        clk;
    logic        reset;
    logic [2:0]  start_v;
    logic [2:0]  tx_v, busy_v, done_v, rd_v;
    logic [5:0]  addr_a, addr_b;
    logic [1:0]  addr_c;
    logic [15:0] rdata_a, rdata_b, rdata_c;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_rise_a, busy_rise_b, busy_rise_c;
    int done_rise_a, done_rise_b, done_rise_c;
    logic [2:0] busy_q = '0, done_q = '0;
    int log0[$], log1[$], log2[$];
    logic [7:0] exp_q[$];

    ram_uart_dumper #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(6), .NUM_WORDS(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .ram_data(rdata_a),
        .ram_addr(addr_a), .ram_rd_en(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    ram_uart_dumper #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(6), .NUM_WORDS(64)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .ram_data(rdata_b),
        .ram_addr(addr_b), .ram_rd_en(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    ram_uart_dumper #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(2), .NUM_WORDS(4)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .ram_data(rdata_c),
        .ram_addr(addr_c), .ram_rd_en(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency RAM models
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rd_v[0]) rdata_a <= (addr_a == 6'd0) ? 16'hA53C : 16'hDEAD;
        if (rd_v[1]) rdata_b <= 16'h0100 + {10'd0, addr_b};
        if (rd_v[2]) rdata_c <= 16'hC0D0 + {14'd0, addr_c};
    end

    always @(negedge clk) begin
        if (busy_v[0] === 1'b1 && busy_q[0] !== 1'b1) busy_rise_a = cyc;
        if (busy_v[1] === 1'b1 && busy_q[1] !== 1'b1) busy_rise_b = cyc;
        if (busy_v[2] === 1'b1 && busy_q[2] !== 1'b1) busy_rise_c = cyc;
        if (done_v[0] === 1'b1 && done_q[0] !== 1'b1) done_rise_a = cyc;
        if (done_v[1] === 1'b1 && done_q[1] !== 1'b1) done_rise_b = cyc;
        if (done_v[2] === 1'b1 && done_q[2] !== 1'b1) done_rise_c = cyc;
        busy_q = busy_v;
        done_q = done_v;
        if (rd_v[0] === 1'b1) log0.push_back(int'(addr_a));
        if (rd_v[1] === 1'b1) log1.push_back(int'(addr_b));
        if (rd_v[2] === 1'b1) log2.push_back(int'(addr_c));
    end

    function automatic logic sig_tx(input int k);
        case (k)
            0: return tx_v[0];
            1: return tx_v[1];
            default: return tx_v[2];
        endcase
    endfunction

    function automatic logic sig_done(input int k);
        case (k)
            0: return done_v[0];
            1: return done_v[1];
            default: return done_v[2];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // status: 0 = good frame, 1 = bad start/stop bit, 2 = no start bit seen
    task automatic rx_byte(input int k, output logic [7:0] b, output int status);
        int n;
        n = 0;
        b = 8'h00;
        status = 2;
        while (sig_tx(k) !== 1'b0 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) return;
        repeat (CPB / 2) @(negedge clk);
        status = (sig_tx(k) === 1'b0) ? 0 : 1;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = sig_tx(k);
        end
        repeat (CPB) @(negedge clk);
        if (sig_tx(k) !== 1'b1) status = 1;
    endtask

    task automatic check_frames(input int k, input int n, input string tag);
        logic [7:0] b, want;
        int st;
        for (int i = 0; i < n; i++) begin
            rx_byte(k, b, st);
            want = exp_q.pop_front();
            chk($sformatf("%s_status%0d", tag, i), 32'(st), 32'd0);
            if (st == 2) begin
                exp_q.delete();
                return;
            end
            chk($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(want));
        end
    endtask

    task automatic wait_done(input int k, input string tag);
        int n;
        n = 0;
        while (sig_done(k) !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sig_done(k)), 32'd1);
    endtask

    initial begin
        int bad;
        reset = 1'b0;
        start_v = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_v[0]), 32'd1);
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_rd_en", 32'(rd_v[0]), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single word 0xA53C, start pulsed
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check_frames(0, 2, "single");
        wait_done(0, "single_done");
        @(negedge clk);
        chk("single_idle_done", 32'(done_v[0]), 32'd0);
        chk("single_idle_busy", 32'(busy_v[0]), 32'd0);
        chk("single_latency", 32'(done_rise_a - busy_rise_a), 32'd83);
        chk("single_reads", 32'(log0.size()), 32'd1);
        if (log0.size() > 0) chk("single_addr", 32'(log0[0]), 32'd0);

        // Reset held for 3 cycles while a frame is in its data bits
        log0.delete();
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("middata_busy_before", 32'(busy_v[0]), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("middata_tx", 32'(tx_v[0]), 32'd1);
        chk("middata_busy", 32'(busy_v[0]), 32'd0);
        chk("middata_done", 32'(done_v[0]), 32'd0);
        chk("middata_addr", 32'(addr_a), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad++;
        end
        chk("post_reset_quiet", 32'(bad), 32'd0);
        chk("post_reset_reads", 32'(log0.size()), 32'd1);

        // Full 64-word sweep with start held high
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(8'h01);
            exp_q.push_back(8'(i));
        end
        log1.delete();
        start_v[1] = 1'b1;
        check_frames(1, 128, "sweep");
        wait_done(1, "sweep_done");
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_v[1] !== 1'b1 || done_v[1] !== 1'b1 || busy_v[1] !== 1'b0 || rd_v[1] !== 1'b0) bad++;
        end
        chk("hold_quiet", 32'(bad), 32'd0);
        chk("sweep_latency", 32'(done_rise_b - busy_rise_b), 32'd5312);
        chk("sweep_reads", 32'(log1.size()), 32'd64);
        for (int i = 0; i < 64 && i < log1.size(); i++)
            chk($sformatf("sweep_addr%0d", i), 32'(log1[i]), 32'(i));

        // Re-arm after one low cycle, then drop start at word 10
        log1.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(8'h01);
            exp_q.push_back(8'(i));
        end
        start_v[1] = 1'b0;
        @(negedge clk);
        start_v[1] = 1'b1;
        check_frames(1, 20, "rearm_a");
        start_v[1] = 1'b0;
        check_frames(1, 108, "rearm_b");
        wait_done(1, "rearm_done");
        @(negedge clk);
        chk("rearm_idle_done", 32'(done_v[1]), 32'd0);
        chk("rearm_idle_busy", 32'(busy_v[1]), 32'd0);
        chk("rearm_latency", 32'(done_rise_b - busy_rise_b), 32'd5312);
        chk("rearm_reads", 32'(log1.size()), 32'd64);
        if (log1.size() == 64) begin
            chk("rearm_first_addr", 32'(log1[0]), 32'd0);
            chk("rearm_last_addr", 32'(log1[63]), 32'd63);
        end

        // Two-bit address, four words: no wrap past the last index
        log2.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hC0);
            exp_q.push_back(8'hD0 + 8'(i));
        end
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        check_frames(2, 8, "small");
        wait_done(2, "small_done");
        repeat (50) @(negedge clk);
        chk("small_latency", 32'(done_rise_c - busy_rise_c), 32'd332);
        chk("small_reads", 32'(log2.size()), 32'd4);
        for (int i = 0; i < 4 && i < log2.size(); i++)
            chk($sformatf("small_addr%0d", i), 32'(log2[i]), 32'(i));
        chk("small_idle_tx", 32'(tx_v[2]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
